// File: rtl/memwb_stage.sv
// Memory-access stage and MEM/WB register; LWL/LWR merge support built only with `define MEMWB_LWLR_EN.
// ALU ops reach MEM/WB in 1 edge, loads/stores in 2+ edges; mem_stall holds EX/MEM until dmem_ack.
module memwb_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exmem_valid,
  input  logic [3:0]        exmem_op,
  input  logic [4:0]        exmem_rd_addr,
  input  logic [31:0]       exmem_alu_result,
  input  logic [31:0]       exmem_store_data,
  input  logic [31:0]       exmem_rt_data,
  output logic [3:0]        exmem_byte_en,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_we,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              mem_align_err,
  output logic [4:0]        memwb_rd_addr,
  output logic [3:0]        memwb_byte_en,
  output logic [31:0]       memwb_data
);

  localparam logic [3:0] OP_ALU = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
`ifdef MEMWB_LWLR_EN
  localparam logic [3:0] OP_LWL = 4'd9;
  localparam logic [3:0] OP_LWR = 4'd10;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [1:0]  k;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        mem_go;
  logic        align_err_now;
  logic [3:0]  lane_mask;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  logic [3:0]  op_q;
  logic [3:0]  be_q;
  logic [1:0]  k_q;
  logic [4:0]  rd_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign k = exmem_alu_result[1:0];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    lane_mask  = 4'b0000;
    st_we      = 4'b0000;
    st_wdata   = exmem_store_data;
    case (exmem_op)
      OP_ALU: lane_mask = 4'b1111;
      OP_LB, OP_LBU: begin
        is_load   = 1'b1;
        lane_mask = 4'b1111;
      end
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        lane_mask  = 4'b1111;
        misaligned = k[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        lane_mask  = 4'b1111;
        misaligned = (k != 2'd0);
      end
      OP_SB: begin
        is_store = 1'b1;
        st_we    = 4'b0001 << k;
        st_wdata = {4{exmem_store_data[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = k[0];
        st_we      = k[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{exmem_store_data[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = (k != 2'd0);
        st_we      = 4'b1111;
      end
`ifdef MEMWB_LWLR_EN
      OP_LWL: begin
        is_load   = 1'b1;
        lane_mask = 4'b1111 << (2'd3 - k);
      end
      OP_LWR: begin
        is_load   = 1'b1;
        lane_mask = 4'b1111 >> k;
      end
`endif
      default: ;
    endcase
  end

  assign mem_go        = exmem_valid && (is_load || is_store) && !misaligned;
  assign align_err_now = exmem_valid && (is_load || is_store) && misaligned;
  assign exmem_byte_en = (exmem_valid && exmem_rd_addr != 5'd0 && !misaligned) ? lane_mask : 4'b0000;
  // Gated by rst so an abandoned access cannot keep the pipeline frozen.
  assign mem_stall     = !rst && ((state == IDLE && mem_go) || (state == BUSY && !dmem_ack));

`ifdef MEMWB_LWLR_EN
  logic [31:0] rt_q;
  logic [3:0]  mrg_mask;
  logic [31:0] mrg_src;
  logic [31:0] mrg_bits;
`else
  logic unused_rt;
  assign unused_rt = ^exmem_rt_data;
`endif

  always_comb begin
    ld_byte = 8'(dmem_rdata >> {k_q, 3'b000});
    ld_half = 16'(dmem_rdata >> {k_q[1], 4'b0000});
    ld_data = 32'd0;
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      OP_LW:   ld_data = dmem_rdata;
      default: ;
    endcase
`ifdef MEMWB_LWLR_EN
    // Lanes outside the partial-word window keep the old rt value.
    mrg_mask = (op_q == OP_LWL) ? (4'b1111 << ~k_q) : (4'b1111 >> k_q);
    mrg_src  = (op_q == OP_LWL) ? (dmem_rdata << {~k_q, 3'b000}) : (dmem_rdata >> {k_q, 3'b000});
    mrg_bits = {{8{mrg_mask[3]}}, {8{mrg_mask[2]}}, {8{mrg_mask[1]}}, {8{mrg_mask[0]}}};
    if (op_q == OP_LWL || op_q == OP_LWR)
      ld_data = (mrg_src & mrg_bits) | (rt_q & ~mrg_bits);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_addr     <= '0;
      dmem_we       <= 4'b0000;
      dmem_wdata    <= 32'd0;
      mem_align_err <= 1'b0;
      memwb_rd_addr <= 5'd0;
      memwb_byte_en <= 4'b0000;
      memwb_data    <= 32'd0;
      op_q          <= 4'd0;
      be_q          <= 4'b0000;
      k_q           <= 2'd0;
      rd_q          <= 5'd0;
`ifdef MEMWB_LWLR_EN
      rt_q          <= 32'd0;
`endif
    end else begin
      mem_align_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_go) begin
            state         <= BUSY;
            dmem_req      <= 1'b1;
            dmem_addr     <= {exmem_alu_result[ADDR_W-1:2], 2'b00};
            dmem_we       <= st_we;
            dmem_wdata    <= st_wdata;
            op_q          <= exmem_op;
            be_q          <= exmem_byte_en;
            k_q           <= k;
            rd_q          <= exmem_rd_addr;
`ifdef MEMWB_LWLR_EN
            rt_q          <= exmem_rt_data;
`endif
            memwb_rd_addr <= 5'd0;
            memwb_byte_en <= 4'b0000;
            memwb_data    <= 32'd0;
          end else begin
            memwb_rd_addr <= exmem_rd_addr;
            memwb_byte_en <= exmem_byte_en;
            memwb_data    <= exmem_alu_result;
            mem_align_err <= align_err_now;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 4'b0000;
            memwb_rd_addr <= rd_q;
            memwb_byte_en <= be_q;
            memwb_data    <= ld_data;
          end else begin
            memwb_rd_addr <= 5'd0;
            memwb_byte_en <= 4'b0000;
            memwb_data    <= 32'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memwb_stage.sv
// Scoreboard bench for memwb_stage: each instruction pushes its expected write-back, popped after commit.
module tb_memwb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_valid;
  logic [3:0]  exmem_op;
  logic [4:0]  exmem_rd_addr;
  logic [31:0] exmem_alu_result;
  logic [31:0] exmem_store_data;
  logic [31:0] exmem_rt_data;
  logic [3:0]  exmem_byte_en;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_align_err;
  logic [4:0]  memwb_rd_addr;
  logic [3:0]  memwb_byte_en;
  logic [31:0] memwb_data;

  always #5 clk = ~clk;

  memwb_stage #(.ADDR_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .exmem_valid      (exmem_valid),
    .exmem_op         (exmem_op),
    .exmem_rd_addr    (exmem_rd_addr),
    .exmem_alu_result (exmem_alu_result),
    .exmem_store_data (exmem_store_data),
    .exmem_rt_data    (exmem_rt_data),
    .exmem_byte_en    (exmem_byte_en),
    .dmem_req         (dmem_req),
    .dmem_addr        (dmem_addr),
    .dmem_we          (dmem_we),
    .dmem_wdata       (dmem_wdata),
    .dmem_ack         (dmem_ack),
    .dmem_rdata       (dmem_rdata),
    .mem_stall        (mem_stall),
    .mem_align_err    (mem_align_err),
    .memwb_rd_addr    (memwb_rd_addr),
    .memwb_byte_en    (memwb_byte_en),
    .memwb_data       (memwb_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
  } wb_t;

  wb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one instruction, plays the memory side (ack in the n_ack-th request cycle), then checks write-back.
  task automatic run_instr(input string name, input logic [3:0] op, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rt,
                           input int n_ack, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_data, input int exp_stalls,
                           input logic [3:0] exp_we, input logic [31:0] exp_wdata, input logic exp_err);
    int  stalls;
    int  busy;
    bit  done;
    wb_t e;
    @(negedge clk);
    exmem_valid      = 1'b1;
    exmem_op         = op;
    exmem_rd_addr    = rd;
    exmem_alu_result = addr;
    exmem_store_data = sd;
    exmem_rt_data    = rt;
    exp_q.push_back('{rd: rd, be: exp_be, data: exp_data, err: exp_err});
    #1;
    chk({name, ".ex_be"}, 32'(exmem_byte_en), 32'(exp_be));
    stalls = 0;
    busy   = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      if (dmem_req) begin
        busy++;
        if (busy == 1) begin
          chk({name, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
          chk({name, ".we"}, 32'(dmem_we), 32'(exp_we));
          if (exp_we != 4'b0000) chk({name, ".wdata"}, dmem_wdata, exp_wdata);
        end
        if (busy >= n_ack) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
          #1;
        end
      end
      if (mem_stall) stalls++;
      else done = 1'b1;
    end
    if (!done) chk({name, ".timeout"}, 32'd0, 32'd1);
    chk({name, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({name, ".req_cycles"}, 32'(busy), 32'(exp_stalls));
    @(posedge clk);
    #1;
    dmem_ack    = 1'b0;
    dmem_rdata  = 32'hDEAD_BEEF;
    exmem_valid = 1'b0;
    e = exp_q.pop_front();
    chk({name, ".wb_be"}, 32'(memwb_byte_en), 32'(e.be));
    if (e.be != 4'b0000) begin
      chk({name, ".wb_rd"}, 32'(memwb_rd_addr), 32'(e.rd));
      chk({name, ".wb_data"}, memwb_data, e.data);
    end
    chk({name, ".align_err"}, 32'(mem_align_err), 32'(e.err));
    chk({name, ".req_after"}, 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    chk({name, ".err_drop"}, 32'(mem_align_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    exmem_valid      = 1'b0;
    exmem_op         = 4'd0;
    exmem_rd_addr    = 5'd0;
    exmem_alu_result = 32'd0;
    exmem_store_data = 32'd0;
    exmem_rt_data    = 32'd0;
    dmem_ack         = 1'b0;
    dmem_rdata       = 32'd0;
    #12;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(mem_stall), 32'd0);
    chk("rst.err", 32'(mem_align_err), 32'd0);
    chk("rst.wb_be", 32'(memwb_byte_en), 32'd0);
    chk("rst.wb_data", memwb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //         name       op     rd    addr          sd            rt            n rdata         be       data          st we       wdata         err
    run_instr("alu",      4'd0,  5'd5, 32'h1234_5678, 32'd0,       32'd0,        0, 32'd0,        4'b1111, 32'h1234_5678, 0, 4'b0000, 32'd0,        1'b0);
    run_instr("lb",       4'd1,  5'd3, 32'h0000_0103, 32'd0,       32'd0,        3, 32'h80FF_EEDD, 4'b1111, 32'hFFFF_FF80, 3, 4'b0000, 32'd0,        1'b0);
    run_instr("lbu",      4'd2,  5'd4, 32'h0000_0102, 32'd0,       32'd0,        1, 32'h80FF_EEDD, 4'b1111, 32'h0000_00FF, 1, 4'b0000, 32'd0,        1'b0);
    run_instr("lh",       4'd3,  5'd6, 32'h0000_0102, 32'd0,       32'd0,        2, 32'h80FF_EEDD, 4'b1111, 32'hFFFF_80FF, 2, 4'b0000, 32'd0,        1'b0);
    run_instr("lhu",      4'd4,  5'd6, 32'h0000_0100, 32'd0,       32'd0,        1, 32'h80FF_EEDD, 4'b1111, 32'h0000_EEDD, 1, 4'b0000, 32'd0,        1'b0);
    run_instr("lw",       4'd5,  5'd9, 32'h0000_0104, 32'd0,       32'd0,        2, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 2, 4'b0000, 32'd0,        1'b0);
    run_instr("sh",       4'd7,  5'd2, 32'h0000_0202, 32'h0000_BEEF, 32'd0,      1, 32'd0,        4'b0000, 32'd0,        1, 4'b1100, 32'hBEEF_BEEF, 1'b0);
    run_instr("sb",       4'd6,  5'd2, 32'h0000_0001, 32'h0000_00A5, 32'd0,      2, 32'd0,        4'b0000, 32'd0,        2, 4'b0010, 32'hA5A5_A5A5, 1'b0);
    run_instr("sw",       4'd8,  5'd2, 32'h0000_0010, 32'h0102_0304, 32'd0,      1, 32'd0,        4'b0000, 32'd0,        1, 4'b1111, 32'h0102_0304, 1'b0);
    run_instr("lw_mis",   4'd5,  5'd9, 32'h0000_0101, 32'd0,       32'd0,        1, 32'd0,        4'b0000, 32'd0,        0, 4'b0000, 32'd0,        1'b1);
    run_instr("sh_mis",   4'd7,  5'd2, 32'h0000_0203, 32'h0000_1111, 32'd0,      1, 32'd0,        4'b0000, 32'd0,        0, 4'b0000, 32'd0,        1'b1);
    run_instr("alu_r0",   4'd0,  5'd0, 32'h0BAD_0BAD, 32'd0,       32'd0,        0, 32'd0,        4'b0000, 32'd0,        0, 4'b0000, 32'd0,        1'b0);
    run_instr("bubble",   4'd12, 5'd7, 32'h0000_0400, 32'd0,       32'd0,        1, 32'd0,        4'b0000, 32'd0,        0, 4'b0000, 32'd0,        1'b0);
`ifdef MEMWB_LWLR_EN
    run_instr("lwl",      4'd9,  5'd10, 32'h0000_0301, 32'd0,      32'h1122_3344, 1, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_3344, 1, 4'b0000, 32'd0,     1'b0);
    run_instr("lwr",      4'd10, 5'd11, 32'h0000_0302, 32'd0,      32'h1122_3344, 2, 32'hAABB_CCDD, 4'b0011, 32'h1122_AABB, 2, 4'b0000, 32'd0,     1'b0);
`else
    run_instr("lwl_off",  4'd9,  5'd10, 32'h0000_0301, 32'd0,      32'h1122_3344, 1, 32'hAABB_CCDD, 4'b0000, 32'd0,       0, 4'b0000, 32'd0,     1'b0);
    run_instr("lwr_off",  4'd10, 5'd11, 32'h0000_0302, 32'd0,      32'h1122_3344, 1, 32'hAABB_CCDD, 4'b0000, 32'd0,       0, 4'b0000, 32'd0,     1'b0);
`endif

    // Reset while an access is outstanding; EX/MEM keeps presenting the load.
    @(negedge clk);
    exmem_valid      = 1'b1;
    exmem_op         = 4'd5;
    exmem_rd_addr    = 5'd7;
    exmem_alu_result = 32'h0000_0400;
    @(negedge clk);
    #1;
    chk("rb.req_busy", 32'(dmem_req), 32'd1);
    chk("rb.stall_busy", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rb.req", 32'(dmem_req), 32'd0);
    chk("rb.stall", 32'(mem_stall), 32'd0);
    chk("rb.wb_be", 32'(memwb_byte_en), 32'd0);
    chk("rb.wb_rd", 32'(memwb_rd_addr), 32'd0);
    chk("rb.wb_data", memwb_data, 32'd0);
    @(negedge clk);
    exmem_valid = 1'b0;
    rst = 1'b0;
    run_instr("alu_post", 4'd0,  5'd8, 32'hA5A5_0001, 32'd0,       32'd0,        0, 32'd0,        4'b1111, 32'hA5A5_0001, 0, 4'b0000, 32'd0,        1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
